// File: rtl/uart_frame_arb_if.sv
// Handshake bundle between the frame arbiter, its two requesters and the
// uart_tx byte transmitter. The slave side is the arbiter itself.
interface uart_frame_arb_if;
    logic       req0;
    logic [7:0] dat0;
    logic       ack0;
    logic       req1;
    logic [7:0] dat1;
    logic       ack1;
    logic       tx_rdy;
    logic [7:0] tx_din;
    logic       tx_din_vld;
    logic       busy;
    logic       gnt_id;
    logic       err;

    modport slave (
        input  req0, dat0, req1, dat1, tx_rdy,
        output ack0, ack1, tx_din, tx_din_vld, busy, gnt_id, err
    );

    modport master (
        output req0, dat0, req1, dat1, tx_rdy,
        input  ack0, ack1, tx_din, tx_din_vld, busy, gnt_id, err
    );
endinterface

// File: rtl/uart_frame_arb.sv
// Round-robin arbiter sharing one uart_tx between two frame requesters.
// Each grant emits a three-byte frame HEAD / payload / TAIL, each byte
// paced by tx_rdy, with a per-byte stall timeout that drops the frame.
module uart_frame_arb #(
    parameter logic [7:0]      HEAD       = 8'h55,
    parameter logic [7:0]      TAIL       = 8'hFF,
    parameter int              TO_W       = 16,
    parameter logic [TO_W-1:0] TX_TIMEOUT = TO_W'(60000)
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_frame_arb_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_e;

    state_e          state_q;
    logic [1:0]      idx_q;
    logic [7:0]      pay_q;
    logic            last_gnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            ack0_q;
    logic            ack1_q;
    logic [7:0]      din_q;
    logic            vld_q;
    logic            busy_q;
    logic            gnt_q;
    logic            err_q;

    logic [7:0]      byte_d;
    logic            pick1_d;
    logic            to_hit_d;

    // Byte selection, grant choice and timeout detect feeding the FSM.
    always_comb begin
        byte_d = HEAD;
        case (idx_q)
            2'd1:    byte_d = pay_q;
            2'd2:    byte_d = TAIL;
            default: byte_d = HEAD;
        endcase
        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        pick1_d  = bus.req1 & (~bus.req0 | ~last_gnt_q);
        to_hit_d = (to_cnt_q == (TX_TIMEOUT - TO_W'(1)));
    end

    // Frame FSM: grant, send each byte, skip one cycle of tx latency, wait ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            pay_q      <= 8'h00;
            last_gnt_q <= 1'b1;
            to_cnt_q   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            din_q      <= 8'h00;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        ack0_q     <= ~pick1_d;
                        ack1_q     <= pick1_d;
                        pay_q      <= pick1_d ? bus.dat1 : bus.dat0;
                        gnt_q      <= pick1_d;
                        last_gnt_q <= pick1_d;
                        busy_q     <= 1'b1;
                        idx_q      <= 2'd0;
                        to_cnt_q   <= '0;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.tx_rdy) begin
                        din_q   <= byte_d;
                        vld_q   <= 1'b1;
                        state_q <= S_GAP;
                    end else if (to_hit_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_GAP: begin
                    // tx_rdy is still high from before the byte was taken; ignore it.
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tx_rdy) begin
                        if (idx_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q    <= idx_q + 2'd1;
                            to_cnt_q <= '0;
                            state_q  <= S_SEND;
                        end
                    end else if (to_hit_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.tx_din     = din_q;
    assign bus.tx_din_vld = vld_q;
    assign bus.busy       = busy_q;
    assign bus.gnt_id     = gnt_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_frame_arb.sv
// Directed bench for uart_frame_arb with a uart_tx model that holds
// tx_rdy low for a fixed number of cycles after each accepted byte.
module tb_uart_frame_arb;

    localparam int TXD = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   stuck = 1'b0;

    uart_frame_arb_if bus ();

    uart_frame_arb #(
        .HEAD       (8'h55),
        .TAIL       (8'hFF),
        .TO_W       (16),
        .TX_TIMEOUT (16'd100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0, ack0_cnt = 0, ack1_cnt = 0, err_cnt = 0;
    int nr_viol = 0, gap_viol = 0, vld_cyc = 0, err_cyc = 0, tx_cnt = 0;
    logic busy_prev = 1'b0;
    logic [7:0] txq[$];
    bit gl[$];

    // Transmitter model plus monitor of acks, bytes, errors and gaps.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            bus.tx_rdy <= 1'b1;
            tx_cnt     <= 0;
            busy_prev  <= 1'b0;
        end else begin
            busy_prev <= bus.busy;
            if (bus.ack0) begin ack0_cnt <= ack0_cnt + 1; gl.push_back(1'b0); end
            if (bus.ack1) begin ack1_cnt <= ack1_cnt + 1; gl.push_back(1'b1); end
            if ((bus.ack0 || bus.ack1) && busy_prev) gap_viol <= gap_viol + 1;
            if (bus.err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
            if (bus.tx_din_vld) begin
                txq.push_back(bus.tx_din);
                vld_cyc <= cyc;
                if (!bus.tx_rdy) nr_viol <= nr_viol + 1;
                bus.tx_rdy <= 1'b0;
                tx_cnt     <= TXD;
            end else if (!stuck && tx_cnt > 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) bus.tx_rdy <= 1'b1;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit which, input string tag);
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = which ? bus.ack1 : bus.ack0;
        end
        check({tag, " ack"}, seen, 1);
    endtask

    task automatic wait_busy_low(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy-low"}, n < 1000, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] pay);
        check({tag, " head"}, txq[base],     8'h55);
        check({tag, " pay"},  txq[base + 1], pay);
        check({tag, " tail"}, txq[base + 2], 8'hFF);
    endtask

    initial begin
        int base, gbase, a0, a1, e0, n, c0, c1;
        bus.req0 = 1'b0; bus.dat0 = 8'h00;
        bus.req1 = 1'b0; bus.dat1 = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        check("rst ack0", bus.ack0, 0);
        check("rst ack1", bus.ack1, 0);
        check("rst tx_din", bus.tx_din, 8'h00);
        check("rst vld", bus.tx_din_vld, 0);
        check("rst busy", bus.busy, 0);
        check("rst gnt_id", bus.gnt_id, 0);
        check("rst err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single frame from requester 0
        base = txq.size(); a0 = ack0_cnt;
        bus.req0 = 1'b1; bus.dat0 = 8'h66;
        wait_ack(1'b0, "t1");
        bus.req0 = 1'b0;
        check("t1 gnt_id", bus.gnt_id, 0);
        check("t1 busy", bus.busy, 1);
        wait_busy_low("t1");
        check("t1 bytes", txq.size() - base, 3);
        check_frame("t1", base, 8'h66);
        check("t1 ack0 count", ack0_cnt - a0, 1);

        // simultaneous requests from reset: 0 first, then 1
        do_reset();
        base = txq.size(); gbase = gl.size();
        bus.req0 = 1'b1; bus.dat0 = 8'h77;
        bus.req1 = 1'b1; bus.dat1 = 8'h33;
        c0 = 0; c1 = 0; n = 0;
        while (!(c0 == 1 && c1 == 1 && bus.busy === 1'b0) && n < 2000) begin
            @(negedge clk); n++;
            if (bus.ack0) begin c0++; bus.req0 = 1'b0; end
            if (bus.ack1) begin c1++; bus.req1 = 1'b0; end
        end
        check("t2 done", n < 2000, 1);
        check("t2 first grant", gl[gbase], 0);
        check("t2 second grant", gl[gbase + 1], 1);
        check("t2 bytes", txq.size() - base, 6);
        check_frame("t2 f0", base, 8'h77);
        check_frame("t2 f1", base + 3, 8'h33);

        // four frames, both requesters keep asking
        do_reset();
        base = txq.size(); gbase = gl.size();
        bus.req0 = 1'b1; bus.dat0 = 8'hA0;
        bus.req1 = 1'b1; bus.dat1 = 8'hB1;
        c0 = 0; c1 = 0; n = 0;
        while (!(c0 == 2 && c1 == 2 && bus.busy === 1'b0) && n < 3000) begin
            @(negedge clk); n++;
            if (bus.ack0) begin c0++; bus.req0 = (c0 < 2); end
            if (bus.ack1) begin c1++; bus.req1 = (c1 < 2); end
        end
        check("t3 done", n < 3000, 1);
        check("t3 g0", gl[gbase],     0);
        check("t3 g1", gl[gbase + 1], 1);
        check("t3 g2", gl[gbase + 2], 0);
        check("t3 g3", gl[gbase + 3], 1);
        check("t3 pay0", txq[base + 1],  8'hA0);
        check("t3 pay1", txq[base + 4],  8'hB1);
        check("t3 pay2", txq[base + 7],  8'hA0);
        check("t3 pay3", txq[base + 10], 8'hB1);
        check("t3 gap", gap_viol, 0);

        // transmitter stalls after HEAD -> timeout abort
        base = txq.size(); e0 = err_cnt;
        stuck = 1'b1;
        bus.req0 = 1'b1; bus.dat0 = 8'h11;
        wait_ack(1'b0, "t4");
        bus.req0 = 1'b0;
        n = 0;
        while (bus.err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("t4 err seen", n < 400, 1);
        check("t4 busy at err", bus.busy, 0);
        @(negedge clk);
        check("t4 err width", bus.err, 0);
        check("t4 err count", err_cnt - e0, 1);
        check("t4 err delay", err_cyc - vld_cyc, 101);
        check("t4 bytes sent", txq.size() - base, 1);
        stuck = 1'b0;
        base = txq.size();
        bus.req0 = 1'b1; bus.dat0 = 8'h42;
        wait_ack(1'b0, "t4 next");
        bus.req0 = 1'b0;
        wait_busy_low("t4 next");
        check_frame("t4 next", base, 8'h42);

        // reset during the payload byte
        base = txq.size();
        bus.req1 = 1'b1; bus.dat1 = 8'hC3;
        wait_ack(1'b1, "t5");
        bus.req1 = 1'b0;
        n = 0;
        while (txq.size() - base < 2 && n < 200) begin @(negedge clk); n++; end
        check("t5 payload sent", n < 200, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst busy", bus.busy, 0);
        check("t5 rst gnt_id", bus.gnt_id, 0);
        check("t5 rst tx_din", bus.tx_din, 8'h00);
        check("t5 rst vld", bus.tx_din_vld, 0);
        check("t5 rst ack1", bus.ack1, 0);
        check("t5 rst err", bus.err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5 no tail", txq.size() - base, 2);
        base = txq.size(); a0 = ack0_cnt; a1 = ack1_cnt;
        bus.req1 = 1'b1; bus.dat1 = 8'h3C;
        wait_ack(1'b1, "t5 after");
        bus.req1 = 1'b0;
        check("t5 gnt_id", bus.gnt_id, 1);
        wait_busy_low("t5 after");
        check("t5 ack1 count", ack1_cnt - a1, 1);
        check("t5 ack0 count", ack0_cnt - a0, 0);
        check_frame("t5 after", base, 8'h3C);

        // payload changes mid-frame do not leak into the frame
        base = txq.size();
        bus.req0 = 1'b1; bus.dat0 = 8'h66;
        wait_ack(1'b0, "t6");
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        bus.dat0 = 8'h99;
        wait_busy_low("t6");
        check_frame("t6", base, 8'h66);
        check("t6 vld vs rdy", nr_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
